projectile_pool: RTL and testbench

- Parametrised pool of NUM_SLOTS independent beam/missile projectiles for the player sprite.
- A fire key press spawns a projectile at the player position in the facing direction, subject to a cooldown.
- Each live projectile moves one horizontal step per frame and despawns at the screen edge or on a collision hit.
- Outputs feed the colour mapper and collision logic. Sits beside the player motion block, clocked by frame_clk.

---
 rtl/proj_pkg.sv | 10 +
 rtl/projectile_slot.sv | 73 +++++++
 rtl/projectile_pool.sv | 87 ++++++++
 tb/tb_projectile_pool.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared types and screen bounds for the player projectile pool.
package proj_pkg;

   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;
   typedef enum logic {SLOT_IDLE = 1'b0, SLOT_FLYING = 1'b1} slot_state_t;

   localparam int unsigned SCREEN_X_MIN = 0;
   localparam int unsigned SCREEN_X_MAX = 639;

endpackage

// File: rtl/projectile_slot.sv
// One projectile: idle/flying FSM, position and direction, with an 11-bit bounds check
// so a step can never wrap the 10-bit X into a live out-of-range value.
module projectile_slot
   import proj_pkg::*;
#(
   parameter int unsigned STEP  = 10,
   parameter int unsigned X_MIN = SCREEN_X_MIN,
   parameter int unsigned X_MAX = SCREEN_X_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spawn,
   input  logic [9:0] spawn_x,
   input  logic [9:0] spawn_y,
   input  dir_t       spawn_dir,
   input  logic       hit,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active
);

   localparam logic [10:0] Step11 = 11'(STEP);
   localparam logic [10:0] XMin11 = 11'(X_MIN);
   localparam logic [10:0] XMax11 = 11'(X_MAX);
   localparam logic [9:0]  Step10 = 10'(STEP);

   slot_state_t state_q;
   dir_t        dir_q;
   logic [9:0]  x_q, y_q;
   logic [10:0] x_ext;
   logic        off_right, off_left;

   assign x_ext     = {1'b0, x_q};
   assign off_right = (x_ext + Step11) > XMax11;
   assign off_left  = x_ext < (XMin11 + Step11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_IDLE;
         dir_q   <= DIR_LEFT;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         unique case (state_q)
            SLOT_IDLE: begin
               if (spawn) begin
                  state_q <= SLOT_FLYING;
                  dir_q   <= spawn_dir;
                  x_q     <= spawn_x;
                  y_q     <= spawn_y;
               end
            end
            SLOT_FLYING: begin
               // Hit beats despawn beats move; X/Y are left as-is on despawn.
               if (hit) begin
                  state_q <= SLOT_IDLE;
               end else if (dir_q == DIR_RIGHT) begin
                  if (off_right) state_q <= SLOT_IDLE;
                  else           x_q     <= x_q + Step10;
               end else begin
                  if (off_left) state_q <= SLOT_IDLE;
                  else          x_q     <= x_q - Step10;
               end
            end
         endcase
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign active = (state_q == SLOT_FLYING);

endmodule

// File: rtl/projectile_pool.sv
// Pool of player projectiles: fire-key edge detect, shot cooldown, lowest-free-slot
// allocation and packing of per-slot state for the colour mapper and collision logic.
module projectile_pool
   import proj_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned STEP      = 10,
   parameter int unsigned X_MIN     = SCREEN_X_MIN,
   parameter int unsigned X_MAX     = SCREEN_X_MAX,
   parameter logic [7:0]  FIRE_KEY  = 8'd13,
   parameter int unsigned COOLDOWN  = 8,
   parameter int unsigned PROJ_SIZE = 4
) (
   input  logic                   frame_clk,
   input  logic                   Reset_n,
   input  logic [7:0]             keycode,
   input  logic [9:0]             player_x,
   input  logic [9:0]             player_y,
   input  logic                   facing,
   input  logic [NUM_SLOTS-1:0]   hit,
   output logic [10*NUM_SLOTS-1:0] proj_x,
   output logic [10*NUM_SLOTS-1:0] proj_y,
   output logic [NUM_SLOTS-1:0]   proj_active,
   output logic [9:0]             proj_size,
   output logic                   fire_ack,
   output logic                   pool_full
);

   logic [7:0]           prev_key_q;
   logic [7:0]           cooldown_q;
   logic                 fire_req;
   logic                 accept;
   logic                 found;
   logic [NUM_SLOTS-1:0] spawn_vec;
   dir_t                 spawn_dir;

   assign pool_full = &proj_active;
   assign fire_req  = (keycode == FIRE_KEY) && (prev_key_q != FIRE_KEY);
   assign accept    = fire_req && (cooldown_q == 8'd0) && !pool_full;
   assign spawn_dir = facing ? DIR_RIGHT : DIR_LEFT;
   assign proj_size = 10'(PROJ_SIZE);

   // Allocation looks at the pre-edge active vector, so a slot freed this frame waits a frame.
   always_comb begin
      spawn_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!proj_active[i] && !found) begin
            spawn_vec[i] = accept;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         prev_key_q <= '0;
         cooldown_q <= '0;
         fire_ack   <= 1'b0;
      end else begin
         prev_key_q <= keycode;
         fire_ack   <= accept;
         if (accept)                  cooldown_q <= 8'(COOLDOWN);
         else if (cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      projectile_slot #(
         .STEP  (STEP),
         .X_MIN (X_MIN),
         .X_MAX (X_MAX)
      ) u_slot (
         .clk       (frame_clk),
         .rst_n     (Reset_n),
         .spawn     (spawn_vec[g]),
         .spawn_x   (player_x),
         .spawn_y   (player_y),
         .spawn_dir (spawn_dir),
         .hit       (hit[g]),
         .x         (proj_x[10*g +: 10]),
         .y         (proj_y[10*g +: 10]),
         .active    (proj_active[g])
      );
   end

endmodule

// File: tb/tb_projectile_pool.sv
// Scenario tests and a randomized run of projectile_pool against a frame-level model.
module tb_projectile_pool;

   localparam int N = 4;

   logic            frame_clk;
   logic            Reset_n;
   logic [7:0]      keycode;
   logic [9:0]      player_x, player_y;
   logic            facing;
   logic [N-1:0]    hit;
   logic [10*N-1:0] proj_x, proj_y;
   logic [N-1:0]    proj_active;
   logic [9:0]      proj_size;
   logic            fire_ack, pool_full;

   int checks = 0;
   int failures = 0;

   // Model state: per-projectile liveness/position/heading plus shot bookkeeping.
   bit m_act[N];
   int m_x[N], m_y[N];
   bit m_right[N];
   int m_cd, m_prev;
   bit m_ack;

   projectile_pool dut (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .keycode     (keycode),
      .player_x    (player_x),
      .player_y    (player_y),
      .facing      (facing),
      .hit         (hit),
      .proj_x      (proj_x),
      .proj_y      (proj_y),
      .proj_active (proj_active),
      .proj_size   (proj_size),
      .fire_ack    (fire_ack),
      .pool_full   (pool_full)
   );

   initial begin
      frame_clk = 1'b0;
      forever #5 frame_clk = ~frame_clk;
   end

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_right[i] = 0;
      end
      m_cd = 0; m_prev = 0; m_ack = 0;
   endtask

   task automatic model_step();
      int  slot;
      bit  take;
      slot = -1;
      for (int i = 0; i < N; i++) if (!m_act[i] && slot < 0) slot = i;
      take = (keycode == 8'd13) && (m_prev != 13) && (m_cd == 0) && (slot >= 0);
      for (int i = 0; i < N; i++) begin
         if (m_act[i]) begin
            if (hit[i]) m_act[i] = 0;
            else if (m_right[i]) begin
               if (m_x[i] + 10 > 639) m_act[i] = 0; else m_x[i] = m_x[i] + 10;
            end else begin
               if (m_x[i] - 10 < 0) m_act[i] = 0; else m_x[i] = m_x[i] - 10;
            end
         end
      end
      if (take) begin
         m_act[slot] = 1; m_x[slot] = int'(player_x); m_y[slot] = int'(player_y);
         m_right[slot] = facing;
      end
      m_cd   = take ? 8 : (m_cd > 0 ? m_cd - 1 : 0);
      m_ack  = take;
      m_prev = int'(keycode);
   endtask

   function automatic logic [85:0] exp_all();
      logic [N-1:0]    a;
      logic [10*N-1:0] xs, ys;
      for (int i = 0; i < N; i++) begin
         a[i] = m_act[i];
         xs[10*i +: 10] = 10'(m_x[i]);
         ys[10*i +: 10] = 10'(m_y[i]);
      end
      return {a, xs, ys, 1'(m_ack), &a};
   endfunction

   task automatic tick();
      model_step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
      model_reset();
   endtask

   task automatic press(input int px, input int py, input bit f);
      keycode = 8'd13; player_x = 10'(px); player_y = 10'(py); facing = f;
      tick();
      keycode = 8'd0;
   endtask

   task automatic idle_frames(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; keycode = 8'd13; player_x = 10'd0; player_y = 10'd0; facing = 1'b0;
      hit = '0;
      #7;
      model_reset();
      checks++;
      if ({proj_active, proj_x, proj_y, fire_ack, pool_full} !== 86'd0) begin
         failures++;
         $display("FAIL reset_state: got %h want 0", {proj_active, proj_x, proj_y, fire_ack});
      end
      checks++;
      if (proj_size !== 10'd4) begin
         failures++;
         $display("FAIL proj_size: got %0d want 4", proj_size);
      end
      keycode = 8'd0;
      Reset_n = 1'b1;
   endtask

   task automatic test_single_shot();
      do_reset();
      press(320, 240, 1'b1);
      checks++;
      if ({fire_ack, proj_active, proj_x[9:0], proj_y[9:0]} !== {1'b1, 4'b0001, 10'd320, 10'd240})
      begin
         failures++;
         $display("FAIL spawn: got ack=%b act=%b x=%0d y=%0d want 1 0001 320 240",
                  fire_ack, proj_active, proj_x[9:0], proj_y[9:0]);
      end
      for (int k = 1; k <= 2; k++) begin
         tick();
         checks++;
         if ({fire_ack, proj_x[9:0]} !== {1'b0, 10'(320 + 10 * k)}) begin
            failures++;
            $display("FAIL move_right_%0d: got ack=%b x=%0d want 0 %0d", k, fire_ack,
                     proj_x[9:0], 320 + 10 * k);
         end
      end
   endtask

   task automatic test_hold_cooldown();
      int acks;
      do_reset();
      acks = 0;
      keycode = 8'd13; player_x = 10'd100; player_y = 10'd50; facing = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (fire_ack) acks++;
      end
      checks++;
      if (acks != 1) begin
         failures++;
         $display("FAIL hold_once: got %0d acks want 1", acks);
      end
      do_reset();
      press(100, 50, 1'b1);
      idle_frames(1);
      press(100, 60, 1'b1);
      checks++;
      if ({fire_ack, proj_active} !== 5'b0_0001) begin
         failures++;
         $display("FAIL cooling_reject: got ack=%b act=%b want 0 0001", fire_ack, proj_active);
      end
      idle_frames(6);
      press(200, 70, 1'b0);
      checks++;
      if ({fire_ack, proj_active, proj_x[19:10]} !== {1'b1, 4'b0011, 10'd200}) begin
         failures++;
         $display("FAIL cooled_accept: got ack=%b act=%b x1=%0d want 1 0011 200",
                  fire_ack, proj_active, proj_x[19:10]);
      end
      checks++;
      if ({proj_active, proj_x, proj_y, fire_ack, pool_full} !== exp_all()) begin
         failures++;
         $display("FAIL cooldown_model: got %h want %h",
                  {proj_active, proj_x, proj_y, fire_ack, pool_full}, exp_all());
      end
   endtask

   task automatic test_bounds();
      do_reset();
      press(625, 100, 1'b1);
      tick();
      checks++;
      if ({proj_active[0], proj_x[9:0]} !== {1'b1, 10'd635}) begin
         failures++;
         $display("FAIL right_635: got act=%b x=%0d want 1 635", proj_active[0], proj_x[9:0]);
      end
      tick();
      checks++;
      if ({proj_active[0], proj_x[9:0]} !== {1'b0, 10'd635}) begin
         failures++;
         $display("FAIL right_edge: got act=%b x=%0d want 0 635", proj_active[0], proj_x[9:0]);
      end
      idle_frames(7);
      press(15, 50, 1'b0);
      tick();
      checks++;
      if ({proj_active[0], proj_x[9:0]} !== {1'b1, 10'd5}) begin
         failures++;
         $display("FAIL left_5: got act=%b x=%0d want 1 5", proj_active[0], proj_x[9:0]);
      end
      tick();
      checks++;
      if ({proj_active[0], proj_x[9:0]} !== {1'b0, 10'd5}) begin
         failures++;
         $display("FAIL left_edge: got act=%b x=%0d want 0 5", proj_active[0], proj_x[9:0]);
      end
   endtask

   task automatic test_pool_full_hit();
      do_reset();
      for (int s = 0; s < N; s++) begin
         press(600, 40 + s, 1'b0);
         if (s < N - 1) idle_frames(8);
      end
      checks++;
      if ({pool_full, proj_active} !== 5'b1_1111) begin
         failures++;
         $display("FAIL pool_full: got full=%b act=%b want 1 1111", pool_full, proj_active);
      end
      idle_frames(8);
      press(300, 300, 1'b1);
      checks++;
      if (fire_ack !== 1'b0) begin
         failures++;
         $display("FAIL full_reject: got ack=%b want 0", fire_ack);
      end
      idle_frames(1);
      hit = 4'b0100;
      press(300, 300, 1'b1);
      hit = '0;
      checks++;
      if ({fire_ack, proj_active} !== 5'b0_1011) begin
         failures++;
         $display("FAIL hit_same_frame: got ack=%b act=%b want 0 1011", fire_ack, proj_active);
      end
      idle_frames(1);
      press(300, 310, 1'b1);
      checks++;
      if ({fire_ack, proj_active, proj_x[29:20], proj_y[29:20]} !==
          {1'b1, 4'b1111, 10'd300, 10'd310}) begin
         failures++;
         $display("FAIL refill_slot2: got ack=%b act=%b x2=%0d y2=%0d want 1 1111 300 310",
                  fire_ack, proj_active, proj_x[29:20], proj_y[29:20]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int s = 0; s < 3; s++) begin
         press(100 + 50 * s, 200, 1'b1);
         if (s < 2) idle_frames(8);
      end
      #3;
      Reset_n = 1'b0;
      #1;
      checks++;
      if ({proj_active, fire_ack, pool_full, proj_x, proj_y} !== 87'd0) begin
         failures++;
         $display("FAIL async_reset: got act=%b ack=%b x=%h want all zero", proj_active,
                  fire_ack, proj_x);
      end
      #1;
      Reset_n = 1'b1;
      model_reset();
      press(400, 100, 1'b0);
      checks++;
      if ({fire_ack, proj_active} !== 5'b1_0001) begin
         failures++;
         $display("FAIL post_reset_fire: got ack=%b act=%b want 1 0001", fire_ack, proj_active);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int f = 0; f < 400; f++) begin
         r = int'($urandom_range(0, 9));
         keycode  = (r < 4) ? 8'd13 : ((r < 6) ? 8'($urandom) : 8'd0);
         player_x = 10'($urandom_range(0, 639));
         player_y = 10'($urandom_range(0, 479));
         facing   = 1'($urandom);
         hit      = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
         tick();
         checks++;
         if ({proj_active, proj_x, proj_y, fire_ack, pool_full} !== exp_all()) begin
            failures++;
            $display("FAIL random_frame_%0d: got %h want %h", f,
                     {proj_active, proj_x, proj_y, fire_ack, pool_full}, exp_all());
         end
      end
      hit = '0;
      keycode = 8'd0;
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_hold_cooldown();
      test_bounds();
      test_pool_full_hit();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
